// File: rtl/nibble_deserializer.sv
// Serial-to-parallel nibble assembler with a one-entry output register,
// sticky drop flag and a modulo-256 count of delivered nibbles.
module nibble_deserializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sof,
    output logic [3:0] a,
    output logic       a_valid,
    input  logic       a_ready,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] count
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t     state;
    logic [1:0] cnt_q,   cnt_d;
    logic [3:0] sh_q,    sh_d;
    logic [3:0] a_q,     a_d;
    logic       av_q,    av_d;
    logic       ov_q,    ov_d;
    logic [7:0] count_q, count_d;
    logic       done;
    logic       xfer;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            a_q     <= '0;
            av_q    <= 1'b0;
            ov_q    <= 1'b0;
            count_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            a_q     <= a_d;
            av_q    <= av_d;
            ov_q    <= ov_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state   = (cnt_q == 2'd0) ? IDLE : COLLECT;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        a_d     = a_q;
        av_d    = av_q;
        ov_d    = ov_q;
        count_d = count_q;
        done    = 1'b0;
        xfer    = av_q && a_ready;

        if (bit_valid) begin
            if (sof) begin
                // Restart: the marker bit becomes the first bit of a fresh nibble.
                sh_d  = MSB_FIRST ? {3'b000, bit_in} : {bit_in, 3'b000};
                cnt_d = 2'd1;
            end else begin
                sh_d  = MSB_FIRST ? {sh_q[2:0], bit_in} : {bit_in, sh_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                done  = (state == COLLECT) && (cnt_q == 2'd3);
            end
        end

        if (xfer) begin
            count_d = count_q + 8'd1;
            av_d    = 1'b0;
        end

        // A nibble completing while the output slot is occupied and not being
        // drained is lost; a same-edge drain frees the slot for it.
        if (done) begin
            if (!av_q || a_ready) begin
                a_d  = sh_d;
                av_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    assign a       = a_q;
    assign a_valid = av_q;
    assign busy    = (state == COLLECT);
    assign overrun = ov_q;
    assign count   = count_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Drives two deserializers (MSB-first and LSB-first) with shared stimulus and
// checks them against a bit-list reference model through per-DUT scoreboards.
module tb_nibble_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sof = 1'b0;
    logic       a_ready = 1'b0;

    logic [3:0] a1, a0;
    logic       av1, av0, busy1, busy0, ov1, ov0;
    logic [7:0] cnt1, cnt0;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // reference model state
    int         bq[$];
    logic [3:0] m_a1 = '0, m_a0 = '0;
    bit         m_valid = 1'b0, m_ov = 1'b0;
    int         m_count = 0;
    logic [3:0] q1[$], q0[$];

    always #5 clk = ~clk;

    nibble_deserializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
        .a(a1), .a_valid(av1), .a_ready(a_ready), .busy(busy1), .overrun(ov1), .count(cnt1)
    );

    nibble_deserializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
        .a(a0), .a_valid(av0), .a_ready(a_ready), .busy(busy0), .overrun(ov0), .count(cnt0)
    );

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_edge(input bit rst_n, input bit bv, input bit b,
                                       input bit s, input bit rdy);
        bit        complete;
        int        msb_val, lsb_val;
        complete = 1'b0;
        msb_val  = 0;
        lsb_val  = 0;
        if (!rst_n) begin
            bq.delete();
            q1.delete();
            q0.delete();
            m_a1 = '0; m_a0 = '0;
            m_valid = 1'b0; m_ov = 1'b0; m_count = 0;
            return;
        end
        if (bv) begin
            if (s) bq = '{int'(b)};
            else   bq.push_back(int'(b));
            if (bq.size() == 4) begin
                complete = 1'b1;
                msb_val = bq[0] * 8 + bq[1] * 4 + bq[2] * 2 + bq[3];
                lsb_val = bq[0] + bq[1] * 2 + bq[2] * 4 + bq[3] * 8;
                bq.delete();
            end
        end
        if (complete) begin
            if (m_valid && rdy) m_count = (m_count + 1) % 256;
            if (!m_valid || rdy) begin
                m_a1 = 4'(msb_val);
                m_a0 = 4'(lsb_val);
                m_valid = 1'b1;
                q1.push_back(m_a1);
                q0.push_back(m_a0);
            end else begin
                m_ov = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_count = (m_count + 1) % 256;
            m_valid = 1'b0;
        end
    endfunction

    task automatic step(input bit rst_n, input bit bv, input bit b, input bit s, input bit rdy);
        reset = rst_n; bit_valid = bv; bit_in = b; sof = s; a_ready = rdy;
        @(posedge clk);
        model_edge(rst_n, bv, b, s, rdy);
        #1;
    endtask

    task automatic send(input logic [3:0] bits_msb_order, input bit rdy_last, input bit rdy_rest);
        logic [3:0] v;
        v = bits_msb_order;
        step(1, 1, v[3], 0, rdy_rest);
        step(1, 1, v[2], 0, rdy_rest);
        step(1, 1, v[1], 0, rdy_rest);
        step(1, 1, v[0], 0, rdy_last);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
    endtask

    // Scoreboard monitor: a nibble is freshly presented when a_valid is high
    // and the previous cycle either had no nibble or handed one off.
    bit prev_v1 = 1'b0, prev_v0 = 1'b0, prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dut1.a_valid", int'(av1), int'(m_valid));
            chk("dut0.a_valid", int'(av0), int'(m_valid));
            chk("dut1.busy", int'(busy1), int'(bq.size() != 0));
            chk("dut0.busy", int'(busy0), int'(bq.size() != 0));
            chk("dut1.overrun", int'(ov1), int'(m_ov));
            chk("dut0.overrun", int'(ov0), int'(m_ov));
            chk("dut1.count", int'(cnt1), m_count);
            chk("dut0.count", int'(cnt0), m_count);
            chk("dut1.a", int'(a1), int'(m_a1));
            chk("dut0.a", int'(a0), int'(m_a0));
            if (av1 && (!prev_v1 || prev_rdy)) begin
                if (q1.size() == 0) chk("dut1.sb_empty", 1, 0);
                else chk("dut1.sb_nibble", int'(a1), int'(q1.pop_front()));
            end
            if (av0 && (!prev_v0 || prev_rdy)) begin
                if (q0.size() == 0) chk("dut0.sb_empty", 1, 0);
                else chk("dut0.sb_nibble", int'(a0), int'(q0.pop_front()));
            end
            prev_v1 = av1;
            prev_v0 = av0;
            prev_rdy = a_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        chk("reset.a", int'(a1), 0);
        chk("reset.count", int'(cnt1), 0);

        // MSB-first 1011 and LSB-first 0001 orderings
        send(4'b1011, 1, 1);
        chk("ord.msb_a", int'(a1), 4'b1011);
        chk("ord.msb_valid", int'(av1), 1);
        step(1, 0, 0, 0, 1);
        chk("ord.count", int'(cnt1), 1);
        send(4'b1000, 1, 1);
        chk("ord.lsb_a", int'(a0), 4'b0001);

        // gaps between bits keep the partial nibble
        do_reset();
        step(1, 1, 0, 0, 0);
        chk("gap.busy1", int'(busy1), 1);
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("gap.busy2", int'(busy1), 1);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("gap.a", int'(a1), 4'b0110);
        chk("gap.busy_end", int'(busy1), 0);
        chk("gap.overrun", int'(ov1), 0);

        // overrun with a_ready held low
        do_reset();
        send(4'h5, 0, 0);
        send(4'hA, 0, 0);
        chk("ovr.a", int'(a1), 4'h5);
        chk("ovr.flag", int'(ov1), 1);
        step(1, 0, 0, 0, 1);
        chk("ovr.count", int'(cnt1), 1);
        chk("ovr.valid", int'(av1), 0);

        // sof restarts a nibble
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("sof.a", int'(a1), 4'h2);
        chk("sof.busy", int'(busy1), 0);

        // drain and reload on the same edge
        do_reset();
        send(4'h3, 0, 0);
        send(4'hC, 1, 0);
        chk("swap.a", int'(a1), 4'hC);
        chk("swap.valid", int'(av1), 1);
        chk("swap.count", int'(cnt1), 1);
        chk("swap.overrun", int'(ov1), 0);

        // mid-nibble reset, then count wrap
        do_reset();
        step(1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 1);
        do_reset();
        chk("rst.a", int'(a1), 0);
        chk("rst.valid", int'(av1), 0);
        chk("rst.busy", int'(busy1), 0);
        chk("rst.overrun", int'(ov1), 0);
        chk("rst.count", int'(cnt1), 0);
        send(4'h9, 1, 1);
        chk("rst.a9", int'(a1), 4'h9);
        for (int i = 0; i < 255; i++) send(4'($urandom_range(0, 15)), 1, 1);
        step(1, 0, 0, 0, 1);
        chk("wrap.count", int'(cnt1), 0);
        chk("wrap.valid", int'(av1), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom));
        end
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        @(negedge clk);
        chk("end.sb1_drained", q1.size(), 0);
        chk("end.sb0_drained", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
